bidir_port_xcvr: RTL and testbench

Half-duplex tristate port controller that owns one end of a shared `inout` bus. It transmits a word onto the bus and otherwise leaves the bus released to `z`, sampling it for inbound words. The block sits where a port-connected `inout` net meets clocked logic. Width adaptation follows port-coercion rules: upper bus bits the block does not drive stay `z`, and excess data bits are truncated.

---
 rtl/bidir_port_pkg.sv | 20 ++
 rtl/bus_tristate_drv.sv | 15 +
 rtl/bidir_port_xcvr.sv | 111 +++++++++++
 tb/tb_bidir_port_xcvr.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bidir_port_pkg.sv
// Shared definitions for the bidirectional port transceiver: state encoding
// and drive-window counter sizing.
package bidir_port_pkg;

   localparam int ST_IDLE    = 0;
   localparam int ST_TURN_TX = 1;
   localparam int ST_DRIVE   = 2;
   localparam int ST_TURN_RX = 3;

   localparam int HOLD_MAX = 15;
   localparam int CNT_W    = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'(ST_IDLE),
      TURN_TX = 2'(ST_TURN_TX),
      DRIVE   = 2'(ST_DRIVE),
      TURN_RX = 2'(ST_TURN_RX)
   } state_t;

endpackage

// File: rtl/bus_tristate_drv.sv
// Per-bit tristate driver; the single point where the shared bus is assigned.
module bus_tristate_drv #(
   parameter int BUS_W = 3
) (
   input  logic             oe,
   input  logic [BUS_W-1:0] data,
   input  logic [BUS_W-1:0] mask,
   inout  wire  [BUS_W-1:0] bus
);

   for (genvar i = 0; i < BUS_W; i++) begin : g_bit
      assign bus[i] = (oe && mask[i]) ? data[i] : 1'bz;
   end

endmodule

// File: rtl/bidir_port_xcvr.sv
// Half-duplex tristate port controller: drives a latched word for HOLD cycles
// between guard states, otherwise releases the bus and samples it on rx_en.
module bidir_port_xcvr
   import bidir_port_pkg::*;
#(
   parameter int BUS_W  = 3,
   parameter int DATA_W = 2,
   parameter int HOLD   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   inout  wire  [BUS_W-1:0]  bus,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   input  logic              rx_en,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   output logic              oe,
   output logic              busy
);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic                capture;
   logic [BUS_W-1:0]    tx_ext;
   logic [BUS_W-1:0]    drv_mask;
   logic [DATA_W-1:0]   bus_word;

   // Width coercion: upper bus bits stay undriven, upper rx bits read as 0.
   for (genvar i = 0; i < BUS_W; i++) begin : g_tx_map
      if (i < DATA_W) begin : g_data
         assign tx_ext[i]   = tx_q[i];
         assign drv_mask[i] = 1'b1;
      end else begin : g_pad
         assign tx_ext[i]   = 1'b0;
         assign drv_mask[i] = 1'b0;
      end
   end

   for (genvar i = 0; i < DATA_W; i++) begin : g_rx_map
      if (i < BUS_W) begin : g_bus
         assign bus_word[i] = bus[i];
      end else begin : g_zero
         assign bus_word[i] = 1'b0;
      end
   end

   assign tx_ready = (state_q == IDLE) && !rx_en;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_en) begin
               capture = 1'b1;
            end else if (tx_valid) begin
               tx_d    = tx_data;
               state_d = TURN_TX;
            end
         end
         TURN_TX: begin
            state_d = DRIVE;
            cnt_d   = CNT_W'(HOLD - 1);
         end
         DRIVE: begin
            if (cnt_q == '0) state_d = TURN_RX;
            else             cnt_d   = cnt_q - 1'b1;
         end
         TURN_RX: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // oe is registered from the next state so the async reset drops it at once.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         tx_q     <= '0;
         oe       <= 1'b0;
         busy     <= 1'b0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tx_q     <= tx_d;
         oe       <= (state_d == DRIVE);
         busy     <= (state_d != IDLE);
         rx_valid <= capture;
         if (capture) rx_data <= bus_word;
      end
   end

   bus_tristate_drv #(
      .BUS_W (BUS_W)
   ) u_drv (
      .oe   (oe),
      .data (tx_ext),
      .mask (drv_mask),
      .bus  (bus)
   );

endmodule

// File: tb/tb_bidir_port_xcvr.sv
// Self-checking bench for bidir_port_xcvr: directed scenarios plus randomized
// traffic checked against a timeline model of accepted words and captures.
module tb_bidir_port_xcvr;

   localparam int HOLD = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Main instance: BUS_W=3, DATA_W=2.
   wire  [2:0] bus;
   logic       tx_valid, rx_en, tx_ready, rx_valid, oe, busy;
   logic [1:0] tx_data, rx_data;
   logic [2:0] peer;

   // Peer releases the bits the block can drive while oe is high; bit 2 is peer-only.
   assign bus[1:0] = oe ? 2'bzz : peer[1:0];
   assign bus[2]   = peer[2];

   bidir_port_xcvr #(.BUS_W(3), .DATA_W(2), .HOLD(HOLD)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_en(rx_en), .rx_valid(rx_valid), .rx_data(rx_data),
      .oe(oe), .busy(busy)
   );

   // Width-swap instance: BUS_W=1, DATA_W=2.
   wire  [0:0] bus_s;
   logic       tv_s, re_s, ready_s, rxv_s, oe_s, busy_s, peer_s;
   logic [1:0] td_s, rxd_s;

   assign bus_s = oe_s ? 1'bz : peer_s;

   bidir_port_xcvr #(.BUS_W(1), .DATA_W(2), .HOLD(HOLD)) u_swap (
      .clk(clk), .rst_n(rst_n), .bus(bus_s),
      .tx_valid(tv_s), .tx_data(td_s), .tx_ready(ready_s),
      .rx_en(re_s), .rx_valid(rxv_s), .rx_data(rxd_s),
      .oe(oe_s), .busy(busy_s)
   );

   int errors = 0;
   int checks = 0;

   // Model: edge index since reset release, edge of last accepted word, captures.
   int         e;
   int         m_acc;
   logic [1:0] m_word;
   logic [1:0] m_rx_data;
   logic       m_rx_valid;

   function automatic bit idle_at(input int k);   // state seen at edge k is IDLE
      return k >= m_acc + HOLD + 3;
   endfunction

   function automatic bit exp_oe(input int k);    // after edge k
      return (k >= m_acc + 1) && (k <= m_acc + HOLD);
   endfunction

   function automatic bit exp_busy(input int k);  // after edge k
      return (k >= m_acc) && (k <= m_acc + HOLD + 1);
   endfunction

   task automatic model_reset();
      e          = 0;
      m_acc      = -1000;
      m_word     = 2'b00;
      m_rx_data  = 2'b00;
      m_rx_valid = 1'b0;
   endtask

   // Drive one cycle from a negedge, update the model for the coming edge,
   // and return at the following negedge. Reports tx_ready before the edge.
   task automatic cycle(input logic tv, input logic [1:0] td, input logic re,
                        input logic [2:0] pv, output logic rdy_obs, output logic rdy_exp);
      tx_valid = tv;
      tx_data  = td;
      rx_en    = re;
      peer     = pv;
      #1;
      rdy_obs = tx_ready;
      rdy_exp = idle_at(e + 1) && !re;
      m_rx_valid = 1'b0;
      if (idle_at(e + 1)) begin
         if (re) begin
            m_rx_data  = pv[1:0];
            m_rx_valid = 1'b1;
         end else if (tv) begin
            m_acc  = e + 1;
            m_word = td;
         end
      end
      @(posedge clk);
      e++;
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n);
      logic ro, rx;
      for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 1'b0, 3'($urandom), ro, rx);
   endtask

   task automatic test_reset();
      logic ro, rx;
      checks++; if (oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", oe); end
      checks++; if (bus !== peer) begin errors++; $display("FAIL reset_bus: got %b want %b (released)", bus, peer); end
      rst_n = 1'b1;
      model_reset();
      cycle(1'b0, 2'b00, 1'b0, 3'b010, ro, rx);
      checks++; if (ro !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", ro); end
      checks++; if (oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_oe_busy: got oe=%b busy=%b want 0 0", oe, busy); end
      checks++; if (rx_data !== 2'b00 || rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx: got data=%b valid=%b want 00 0", rx_data, rx_valid); end
      checks++; if (bus !== 3'b010) begin errors++; $display("FAIL reset_release_bus: got %b want 010", bus); end
   endtask

   task automatic test_tx_word();
      logic ro, rx;
      int oe_cycles = 0;
      cycle(1'b1, 2'b10, 1'b0, 3'b011, ro, rx);
      checks++; if (ro !== 1'b1) begin errors++; $display("FAIL tx_accept_ready: got %b want 1", ro); end
      for (int k = 0; k <= HOLD + 3; k++) begin
         logic want_oe;
         want_oe = (k >= 1) && (k <= HOLD);
         if (oe === 1'b1) oe_cycles++;
         checks++; if (oe !== want_oe) begin errors++; $display("FAIL tx_oe[%0d]: got %b want %b", k, oe, want_oe); end
         checks++; if (want_oe && bus !== {peer[2], 2'b10}) begin errors++; $display("FAIL tx_bus[%0d]: got %b want %b10", k, bus, peer[2]); end
         checks++; if (tx_ready !== (k >= HOLD + 2)) begin errors++; $display("FAIL tx_ready_return[%0d]: got %b want %b", k, tx_ready, k >= HOLD + 2); end
         cycle(1'b0, 2'($urandom), 1'b0, 3'($urandom), ro, rx);
      end
      checks++; if (oe_cycles != HOLD) begin errors++; $display("FAIL tx_drive_len: got %0d want %0d", oe_cycles, HOLD); end
   endtask

   task automatic test_rx_word();
      logic ro, rx;
      cycle(1'b0, 2'b00, 1'b1, 3'b101, ro, rx);
      checks++; if (ro !== 1'b0) begin errors++; $display("FAIL rx_tx_ready: got %b want 0", ro); end
      checks++; if (rx_data !== 2'b01 || rx_valid !== 1'b1) begin errors++; $display("FAIL rx_capture: got data=%b valid=%b want 01 1", rx_data, rx_valid); end
      cycle(1'b0, 2'b00, 1'b0, 3'b000, ro, rx);
      checks++; if (rx_data !== 2'b01 || rx_valid !== 1'b0) begin errors++; $display("FAIL rx_pulse_end: got data=%b valid=%b want 01 0", rx_data, rx_valid); end
   endtask

   task automatic test_simultaneous();
      logic ro, rx;
      cycle(1'b1, 2'b01, 1'b1, 3'b110, ro, rx);
      checks++; if (ro !== 1'b0) begin errors++; $display("FAIL simul_ready: got %b want 0", ro); end
      checks++; if (rx_data !== 2'b10 || rx_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL simul_capture: got data=%b valid=%b busy=%b want 10 1 0", rx_data, rx_valid, busy); end
      cycle(1'b1, 2'b01, 1'b0, 3'b000, ro, rx);
      checks++; if (ro !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL simul_accept: got ready=%b busy=%b want 1 1", ro, busy); end
      cycle(1'b0, 2'b00, 1'b0, 3'b110, ro, rx);
      checks++; if (oe !== 1'b1 || bus[1:0] !== 2'b01) begin errors++; $display("FAIL simul_drive: got oe=%b bus=%b want 1 x01", oe, bus); end
      idle_cycles(HOLD + 2);
   endtask

   task automatic test_random();
      logic ro, rx;
      logic [1:0] want_lo;
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0), 3'($urandom), ro, rx);
         want_lo = exp_oe(e) ? m_word : peer[1:0];
         checks++; if (ro !== rx) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, ro, rx); end
         checks++; if (oe !== exp_oe(e) || busy !== exp_busy(e)) begin errors++; $display("FAIL rand_oe_busy[%0d]: got %b%b want %b%b", i, oe, busy, exp_oe(e), exp_busy(e)); end
         checks++; if (rx_valid !== m_rx_valid || rx_data !== m_rx_data) begin errors++; $display("FAIL rand_rx[%0d]: got %b/%b want %b/%b", i, rx_valid, rx_data, m_rx_valid, m_rx_data); end
         checks++; if (bus !== {peer[2], want_lo}) begin errors++; $display("FAIL rand_bus[%0d]: got %b want %b", i, bus, {peer[2], want_lo}); end
      end
      idle_cycles(HOLD + 3);
   endtask

   task automatic test_width_swap();
      tv_s = 1'b1; td_s = 2'b10; peer_s = 1'b1; re_s = 1'b0;
      #1;
      checks++; if (ready_s !== 1'b1) begin errors++; $display("FAIL swap_ready: got %b want 1", ready_s); end
      idle_cycles(1);
      tv_s = 1'b0;
      idle_cycles(1);
      checks++; if (oe_s !== 1'b1 || bus_s !== 1'b0) begin errors++; $display("FAIL swap_tx_bus: got oe=%b bus=%b want 1 0", oe_s, bus_s); end
      idle_cycles(HOLD + 1);
      checks++; if (ready_s !== 1'b1 || oe_s !== 1'b0) begin errors++; $display("FAIL swap_idle: got ready=%b oe=%b want 1 0", ready_s, oe_s); end
      peer_s = 1'b1; re_s = 1'b1;
      idle_cycles(1);
      checks++; if (rxd_s !== 2'b01 || rxv_s !== 1'b1) begin errors++; $display("FAIL swap_rx1: got data=%b valid=%b want 01 1", rxd_s, rxv_s); end
      peer_s = 1'b0;
      idle_cycles(1);
      re_s = 1'b0;
      checks++; if (rxd_s !== 2'b00) begin errors++; $display("FAIL swap_rx0: got %b want 00", rxd_s); end
   endtask

   task automatic test_reset_mid_drive();
      logic ro, rx;
      cycle(1'b1, 2'b11, 1'b0, 3'b000, ro, rx);
      cycle(1'b0, 2'b00, 1'b0, 3'b000, ro, rx);
      cycle(1'b0, 2'b00, 1'b0, 3'b000, ro, rx);
      checks++; if (oe !== 1'b1 || bus[1:0] !== 2'b11) begin errors++; $display("FAIL mid_second_drive: got oe=%b bus=%b want 1 x11", oe, bus); end
      rst_n = 1'b0;
      #1;
      checks++; if (oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async_release: got oe=%b busy=%b want 0 0", oe, busy); end
      checks++; if (bus !== peer) begin errors++; $display("FAIL mid_bus_released: got %b want %b", bus, peer); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < HOLD + 4; i++) begin
         cycle(1'b0, 2'b00, 1'b0, 3'b000, ro, rx);
         checks++; if (oe !== 1'b0 || busy !== 1'b0 || ro !== 1'b1) begin errors++; $display("FAIL mid_no_resend[%0d]: got oe=%b busy=%b ready=%b want 0 0 1", i, oe, busy, ro); end
      end
   endtask

   initial begin
      tx_valid = 1'b0; tx_data = 2'b00; rx_en = 1'b0; peer = 3'b101;
      tv_s = 1'b0; td_s = 2'b00; re_s = 1'b0; peer_s = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      test_reset();
      test_tx_word();
      test_rx_word();
      test_simultaneous();
      test_random();
      test_width_swap();
      test_reset_mid_drive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
